// File: rtl/connector_pkg.sv
// Shared trace-connector definitions: itype codes, branch-map sizing and record reasons.
// The itype detector and the branch map builder both use these codes.
package connector_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned ITYPE_LEN = 3;
  localparam int unsigned BMAP_LEN  = 31;

  typedef enum logic [1:0] {FULL, DISCON, EXC, ERET} bmap_reason_t;
  typedef enum logic {BUF_EMPTY, BUF_HOLD} bmap_buf_state_t;

  localparam logic [3:0] ITYPE_NONE         = 4'd0;
  localparam logic [3:0] ITYPE_EXC          = 4'd1;
  localparam logic [3:0] ITYPE_INT          = 4'd2;
  localparam logic [3:0] ITYPE_ERET         = 4'd3;
  localparam logic [3:0] ITYPE_NONTAKEN     = 4'd4;
  localparam logic [3:0] ITYPE_TAKEN        = 4'd5;
  localparam logic [3:0] ITYPE_UNINF_JUMP   = 4'd6;
  localparam logic [3:0] ITYPE_UNINF_JUMP_W = 4'd8;
  localparam logic [3:0] ITYPE_UNINF_CALL_W = 4'd10;

  typedef struct packed {
    logic         branch;
    logic         nontaken;
    logic         close;
    bmap_reason_t reason;
  } itype_dec_t;

  // The itype is zero-extended to 4 bits; 'wide' selects the 4-bit code space.
  function automatic itype_dec_t decode_itype(input logic [3:0] itype, input logic wide);
    itype_dec_t d;
    d = '0;
    case (itype)
      ITYPE_EXC, ITYPE_INT: begin
        d.close  = 1'b1;
        d.reason = EXC;
      end
      ITYPE_ERET: begin
        d.close  = 1'b1;
        d.reason = ERET;
      end
      ITYPE_NONTAKEN: begin
        d.branch   = 1'b1;
        d.nontaken = 1'b1;
      end
      ITYPE_TAKEN: d.branch = 1'b1;
      ITYPE_UNINF_JUMP: begin
        d.close  = !wide;
        d.reason = DISCON;
      end
      ITYPE_UNINF_JUMP_W, ITYPE_UNINF_CALL_W: begin
        d.close  = wide;
        d.reason = DISCON;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/branch_map_accum.sv
// Branch map accumulator: collects taken/not-taken bits and produces the closing
// record combinationally in the cycle a close condition is accepted.
module branch_map_accum #(
  parameter int unsigned XLEN      = connector_pkg::XLEN,
  parameter int unsigned ITYPE_LEN = connector_pkg::ITYPE_LEN,
  parameter int unsigned BMAP_LEN  = connector_pkg::BMAP_LEN
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 accept_i,
  input  logic                 flush_i,
  input  logic [ITYPE_LEN-1:0] itype_i,
  input  logic [XLEN-1:0]      pc_i,
  output logic                 close_o,
  output logic [4:0]           branches_o,
  output logic [BMAP_LEN-1:0]  map_o,
  output logic [XLEN-1:0]      addr_o,
  output logic [1:0]           reason_o
);
  import connector_pkg::*;

  logic [4:0]          r_count;
  logic [BMAP_LEN-1:0] r_map;

  itype_dec_t          w_dec;
  logic [3:0]          w_itype4;
  logic                w_branch;
  logic                w_full;
  logic [4:0]          w_count_inc;
  logic [BMAP_LEN-1:0] w_map_next;

  assign w_itype4    = 4'(itype_i);
  assign w_dec       = decode_itype(w_itype4, ITYPE_LEN == 4);
  assign w_branch    = accept_i && !flush_i && w_dec.branch;
  assign w_count_inc = r_count + 5'd1;
  assign w_full      = w_branch && (w_count_inc == 5'(BMAP_LEN));
  assign close_o     = accept_i && !flush_i && (w_dec.close || w_full);

  // Only the bit at the current count can change; higher bits stay 0 from the last clear.
  generate
    for (genvar gi = 0; gi < BMAP_LEN; gi++) begin : g_map_bit
      assign w_map_next[gi] = r_map[gi] | (w_branch && w_dec.nontaken && (r_count == 5'(gi)));
    end
  endgenerate

  assign branches_o = w_branch ? w_count_inc : r_count;
  assign map_o      = w_map_next;
  assign addr_o     = pc_i;
  assign reason_o   = w_full ? FULL : w_dec.reason;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
      r_map   <= '0;
    end else if (flush_i || close_o) begin
      r_count <= '0;
      r_map   <= '0;
    end else if (w_branch) begin
      r_count <= w_count_inc;
      r_map   <= w_map_next;
    end
  end

endmodule

// File: rtl/branch_map_builder.sv
// Branch map builder: accumulator plus a one-entry record buffer toward the packet emitter.
// A close in the same cycle as the drain reloads the buffer back-to-back.
module branch_map_builder #(
  parameter int unsigned XLEN      = connector_pkg::XLEN,
  parameter int unsigned ITYPE_LEN = connector_pkg::ITYPE_LEN,
  parameter int unsigned BMAP_LEN  = connector_pkg::BMAP_LEN
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [ITYPE_LEN-1:0] itype_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic                 flush_i,
  output logic                 rec_valid_o,
  input  logic                 rec_ready_i,
  output logic [4:0]           rec_branches_o,
  output logic [BMAP_LEN-1:0]  rec_map_o,
  output logic [XLEN-1:0]      rec_addr_o,
  output logic [1:0]           rec_reason_o
);
  import connector_pkg::*;

  bmap_buf_state_t     r_state;
  logic                r_init;
  logic [4:0]          r_branches;
  logic [BMAP_LEN-1:0] r_map;
  logic [XLEN-1:0]     r_addr;
  logic [1:0]          r_reason;

  logic                w_accept;
  logic                w_close;
  logic [4:0]          w_branches;
  logic [BMAP_LEN-1:0] w_map;
  logic [XLEN-1:0]     w_addr;
  logic [1:0]          w_reason;

  // r_init keeps ready_o low through reset and the first edge after release.
  assign ready_o  = r_init && ((r_state == BUF_EMPTY) || rec_ready_i);
  assign w_accept = valid_i && ready_o;

  branch_map_accum #(
    .XLEN      (XLEN),
    .ITYPE_LEN (ITYPE_LEN),
    .BMAP_LEN  (BMAP_LEN)
  ) u_accum (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .accept_i   (w_accept),
    .flush_i    (flush_i),
    .itype_i    (itype_i),
    .pc_i       (pc_i),
    .close_o    (w_close),
    .branches_o (w_branches),
    .map_o      (w_map),
    .addr_o     (w_addr),
    .reason_o   (w_reason)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= BUF_EMPTY;
      r_init     <= 1'b0;
      r_branches <= '0;
      r_map      <= '0;
      r_addr     <= '0;
      r_reason   <= '0;
    end else begin
      r_init <= 1'b1;
      case (r_state)
        BUF_EMPTY: begin
          if (w_close) begin
            r_state    <= BUF_HOLD;
            r_branches <= w_branches;
            r_map      <= w_map;
            r_addr     <= w_addr;
            r_reason   <= w_reason;
          end
        end
        BUF_HOLD: begin
          if (rec_ready_i) begin
            if (w_close) begin
              r_branches <= w_branches;
              r_map      <= w_map;
              r_addr     <= w_addr;
              r_reason   <= w_reason;
            end else begin
              r_state <= BUF_EMPTY;
            end
          end
        end
        default: r_state <= BUF_EMPTY;
      endcase
    end
  end

  assign rec_valid_o    = (r_state == BUF_HOLD);
  assign rec_branches_o = r_branches;
  assign rec_map_o      = r_map;
  assign rec_addr_o     = r_addr;
  assign rec_reason_o   = r_reason;

endmodule

// File: tb/tb_branch_map_builder.sv
// Directed bench for branch_map_builder with hand-computed expected records.
module tb_branch_map_builder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  itype_i;
  logic [63:0] pc_i;
  logic        flush_i;
  logic        rec_valid_o;
  logic        rec_ready_i;
  logic [4:0]  rec_branches_o;
  logic [30:0] rec_map_o;
  logic [63:0] rec_addr_o;
  logic [1:0]  rec_reason_o;

  int n_cmp = 0;
  int n_bad = 0;

  branch_map_builder dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .itype_i        (itype_i),
    .pc_i           (pc_i),
    .flush_i        (flush_i),
    .rec_valid_o    (rec_valid_o),
    .rec_ready_i    (rec_ready_i),
    .rec_branches_o (rec_branches_o),
    .rec_map_o      (rec_map_o),
    .rec_addr_o     (rec_addr_o),
    .rec_reason_o   (rec_reason_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one input and wait (bounded) until it is accepted.
  task automatic send(input logic [2:0] it, input logic [63:0] pc);
    int n;
    valid_i = 1'b1;
    itype_i = it;
    pc_i    = pc;
    n = 0;
    while (!ready_o && n < 50) begin
      step();
      n++;
    end
    if (!ready_o) check("send_ready_timeout", 64'(ready_o), 64'd1);
    step();
    valid_i = 1'b0;
  endtask

  task automatic check_rec(input string tag, input logic [4:0] br, input logic [30:0] map,
                           input logic [63:0] addr, input logic [1:0] reason);
    check({tag, "_valid"}, 64'(rec_valid_o), 64'd1);
    check({tag, "_branches"}, 64'(rec_branches_o), 64'(br));
    check({tag, "_map"}, 64'(rec_map_o), 64'(map));
    check({tag, "_addr"}, rec_addr_o, addr);
    check({tag, "_reason"}, 64'(rec_reason_o), 64'(reason));
  endtask

  initial begin
    rst_ni      = 1'b0;
    valid_i     = 1'b0;
    itype_i     = '0;
    pc_i        = '0;
    flush_i     = 1'b0;
    rec_ready_i = 1'b0;

    // Reset state
    step();
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_valid", 64'(rec_valid_o), 64'd0);
    check("rst_addr", rec_addr_o, 64'd0);
    #3 rst_ni = 1'b1;
    step();
    check("rst_ready_after", 64'(ready_o), 64'd1);

    // Taken, nontaken, nontaken then uninferable jump
    send(3'd5, 64'h10);
    send(3'd4, 64'h14);
    send(3'd4, 64'h18);
    check("t1_no_rec_yet", 64'(rec_valid_o), 64'd0);
    send(3'd6, 64'h8000_0100);
    check_rec("t1", 5'd3, 31'b110, 64'h8000_0100, 2'd1);
    rec_ready_i = 1'b1;
    step();
    check("t1_drained", 64'(rec_valid_o), 64'd0);

    // 31 nontaken branches fill the map
    for (int i = 0; i < 31; i++) send(3'd4, 64'h1000 + 64'(4 * i));
    check_rec("t2_full", 5'd31, 31'h7FFF_FFFF, 64'h1078, 2'd0);
    send(3'd5, 64'h2000);
    check("t2_drained", 64'(rec_valid_o), 64'd0);
    send(3'd6, 64'h3000);
    check_rec("t2_next", 5'd1, 31'd0, 64'h3000, 2'd1);
    step();

    // Exception with empty map, then backpressure with an eret waiting
    send(3'd1, 64'h100);
    check_rec("t3_exc", 5'd0, 31'd0, 64'h100, 2'd2);
    rec_ready_i = 1'b0;
    valid_i = 1'b1;
    itype_i = 3'd3;
    pc_i    = 64'h200;
    step();
    step();
    check("t3_ready_low", 64'(ready_o), 64'd0);
    check("t3_hold_addr", rec_addr_o, 64'h100);
    check("t3_hold_reason", 64'(rec_reason_o), 64'd2);
    rec_ready_i = 1'b1;
    #1;
    check("t3_ready_high", 64'(ready_o), 64'd1);
    step();
    valid_i = 1'b0;
    check_rec("t3_eret", 5'd0, 31'd0, 64'h200, 2'd3);
    step();
    check("t3_drained", 64'(rec_valid_o), 64'd0);

    // Flush beats a simultaneous discontinuity
    send(3'd4, 64'h300);
    send(3'd5, 64'h304);
    send(3'd4, 64'h308);
    send(3'd4, 64'h30c);
    send(3'd5, 64'h310);
    flush_i = 1'b1;
    send(3'd6, 64'h314);
    flush_i = 1'b0;
    check("t4_no_rec", 64'(rec_valid_o), 64'd0);
    step();
    check("t4_still_no_rec", 64'(rec_valid_o), 64'd0);
    send(3'd6, 64'h400);
    check_rec("t4_after_flush", 5'd0, 31'd0, 64'h400, 2'd1);
    step();

    // Asynchronous reset while holding a record
    send(3'd4, 64'h40);
    send(3'd4, 64'h44);
    send(3'd5, 64'h48);
    send(3'd4, 64'h4c);
    rec_ready_i = 1'b0;
    send(3'd6, 64'h50);
    check("t5_hold", 64'(rec_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("t5_rst_valid", 64'(rec_valid_o), 64'd0);
    check("t5_rst_branches", 64'(rec_branches_o), 64'd0);
    check("t5_rst_ready", 64'(ready_o), 64'd0);
    #2 rst_ni = 1'b1;
    step();
    rec_ready_i = 1'b1;
    send(3'd7, 64'h60);
    send(3'd0, 64'h64);
    send(3'd4, 64'h68);
    send(3'd7, 64'h6c);
    send(3'd0, 64'h70);
    send(3'd6, 64'h500);
    check_rec("t5_after_rst", 5'd1, 31'd1, 64'h500, 2'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
